serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Digit-serial subtractor: computes a - b - bin one digit_width-bit slice
//   per clock, rippling the borrow through a single flop. Operands enter and
//   results leave over valid/ready handshakes.
//
//   Parameters
//     width        operand/result width (integer multiple of digit_width)
//     digit_width  bits processed per clock (1..width)
//
//   Ports
//     clk        clock, all state updates on posedge
//     rst        synchronous active-high reset
//     in_valid   operand set presented
//     in_ready   block can accept operands (IDLE)
//     a, b, bin  minuend, subtrahend, borrow-in
//     out_valid  result held on diff/bout (DONE)
//     out_ready  consumer accepts result
//     diff       (a - b - bin) mod 2^width
//     bout       borrow-out, 1 iff a < b + bin (unsigned)
//     ovf        signed overflow, present only with SERIAL_SUBTRACTOR_OVF_EN
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   BUSY  | one digit subtracted per clock
//   DONE  | result held, out_valid=1, waiting for out_ready
module serial_subtractor #(
  parameter int width       = 8,
  parameter int digit_width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int ndig  = width / digit_width;
  localparam int cnt_w = (ndig > 1) ? $clog2(ndig) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [width-1:0]       a_reg;
  logic [width-1:0]       b_reg;
  logic [cnt_w-1:0]       cnt;
  logic [digit_width:0]   dsub;
  logic [width-1:0]       dig_ext;
  logic                   last_digit;

  // bout doubles as the running borrow flop; its final value is the borrow-out.
  assign dsub = {1'b0, a_reg[digit_width-1:0]}
              - {1'b0, b_reg[digit_width-1:0]}
              - {{digit_width{1'b0}}, bout};

  assign dig_ext    = width'(dsub[digit_width-1:0]);
  assign last_digit = (cnt == cnt_w'(ndig - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            bout  <= bin;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Result digits enter at the top so the LSB digit ends at bit 0.
          diff  <= (diff >> digit_width) | (dig_ext << (width - digit_width));
          a_reg <= a_reg >> digit_width;
          b_reg <= b_reg >> digit_width;
          bout  <= dsub[digit_width];
          if (last_digit) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the last digit the low-digit MSBs are the operand/result sign bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == BUSY && last_digit) begin
      ovf <= (a_reg[digit_width-1] ^ b_reg[digit_width-1])
           & (dsub[digit_width-1] ^ a_reg[digit_width-1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [4];
  logic       in_ready  [4];
  logic [7:0] a_s       [4];
  logic [7:0] b_s       [4];
  logic       bin_s     [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [7:0] diff      [4];
  logic       bout      [4];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf       [4];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance k uses digit_width = 2**k (1, 2, 4, 8).
  for (genvar k = 0; k < 4; k++) begin : g_dut
    serial_subtractor #(.width(8), .digit_width(1 << k)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .a         (a_s[k]),
      .b         (b_s[k]),
      .bin       (bin_s[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .diff      (diff[k]),
      .bout      (bout[k])
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf       (ovf[k])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one operation on instance k; called at #1 after a posedge with the
  // instance idle. hold = cycles of out_ready=0 backpressure in DONE.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input int hold);
    int         lat;
    int         ndig;
    logic [8:0] exp;
    logic       exp_ovf;
    ndig = 8 >> k;
    exp  = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    exp_ovf = (av[7] != bv[7]) && (exp[7] != av[7]);
    chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
    a_s[k] = av; b_s[k] = bv; bin_s[k] = bi; in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a_s[k] = 8'($urandom); b_s[k] = 8'($urandom); bin_s[k] = 1'($urandom);
    lat = 0;
    while (!out_valid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    // +1: the edge after DONE is entered is the first that samples out_valid=1.
    chk("latency", 32'(lat + 1), 32'(ndig + 1));
    chk("diff", 32'(diff[k]), 32'(exp[7:0]));
    chk("bout", 32'(bout[k]), 32'(exp[8]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", 32'(ovf[k]), 32'(exp_ovf));
`endif
    if (hold > 0) begin
      // A new operand presented while DONE must be ignored.
      a_s[k] = ~av; b_s[k] = 8'($urandom); in_valid[k] = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      in_valid[k] = 1'b0;
      chk("hold_valid", 32'(out_valid[k]), 32'd1);
      chk("hold_in_ready", 32'(in_ready[k]), 32'd0);
      chk("hold_diff", 32'(diff[k]), 32'(exp[7:0]));
      chk("hold_bout", 32'(bout[k]), 32'(exp[8]));
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("post_valid", 32'(out_valid[k]), 32'd0);
    chk("post_in_ready", 32'(in_ready[k]), 32'd1);
  endtask

  initial begin
    logic [7:0] ca [7];
    logic [7:0] cb [7];
    logic       cbi[7];
    ca = '{8'h00, 8'hAA, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'h10};
    cb = '{8'h00, 8'hAA, 8'hFF, 8'hFF, 8'h01, 8'hFF, 8'h05};
    cbi = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      a_s[k] = 8'h00; b_s[k] = 8'h00; bin_s[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", 32'(in_ready[k]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
      chk("rst_diff", 32'(diff[k]), 32'd0);
      chk("rst_bout", 32'(bout[k]), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("rst_ovf", 32'(ovf[k]), 32'd0);
`endif
    end
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(0, 8'h5A, 8'h23, 1'b0, 0);
    run_op(0, 8'h00, 8'h01, 1'b0, 0);
    run_op(0, 8'h00, 8'h00, 1'b1, 0);
    run_op(0, 8'h33, 8'h44, 1'b1, 5);

    // Reset during the 4th BUSY cycle discards the operation.
    a_s[0] = 8'h12; b_s[0] = 8'h34; bin_s[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      chk("midrst_no_output", 32'(out_valid[0]), 32'd0);
    end
    run_op(0, 8'hFF, 8'h0F, 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 7; i++) run_op(k, ca[i], cb[i], cbi[i], 0);
      for (int i = 0; i < 250; i++)
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
